// File: rtl/run_reporter_pkg.sv
// ---------------------------------------------------------------------------
// run_reporter_pkg
// Shared types and constants for the run reporter.
//   state_t : run-delimiting FSM states (IDLE, IN_RUN)
//   MIN_RUN : length of a run on the cycle the detector first flags it
// The {polarity, length} record type depends on LEN_W, and a package cannot
// take parameters, so the record struct is declared inside run_reporter next
// to its parameter. The FIFO stores it as a plain packed vector.
// Optional feature macro used by this slice: RUN_MAXLEN_EN.
// ---------------------------------------------------------------------------
package run_reporter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_RUN = 1'b1
    } state_t;

    // The detector raises its flag once three equal bits have been seen.
    localparam int MIN_RUN = 3;

endpackage

// File: rtl/run_rec_fifo.sv
// ---------------------------------------------------------------------------
// run_rec_fifo
// Synchronous FIFO of run records with a combinational head read.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write i_wr_data this edge (if there is room)
//   i_pop      : remove the head this edge (ignored when empty)
//   i_wr_data  : record to write
//   o_rd_data  : current head record (undefined while empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
// ---------------------------------------------------------------------------
module run_rec_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    import run_reporter_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // The extra pointer MSB distinguishes full from empty when the slot
    // indices coincide.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // When full, the slot being written is the one being popped this edge.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; entries are only read once written, and the
    // top masks the head output while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/run_reporter.sv
// ---------------------------------------------------------------------------
// run_reporter
// Delimits each run of >=3 equal serial bits flagged by the equal-run
// detector, measures its length (saturating), and queues one {polarity,
// length} record per run for a valid/ready consumer. Counts completed runs
// (including dropped ones) and keeps a sticky overflow flag.
// Optional feature: define RUN_MAXLEN_EN to add max_len, the longest run
// closed since reset.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   match_in   : detector flag, high while the last >=3 bits are equal
//   bit_in     : serial bit aligned with match_in (run polarity)
//   rec_ready  : consumer takes the head record this edge
//   ovf_clr    : synchronous clear of ovf (a same-edge drop wins)
//   rec_valid  : a record is available
//   rec_bit    : head record polarity (0 while empty)
//   rec_len    : head record length (0 while empty)
//   run_count  : completed runs, wraps modulo 2^CNT_W
//   ovf        : sticky, a record was dropped on a full FIFO
//   max_len    : (RUN_MAXLEN_EN only) longest closed run
// ---------------------------------------------------------------------------
module run_reporter #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             match_in,
    input  logic             bit_in,
    input  logic             rec_ready,
    input  logic             ovf_clr,
    output logic             rec_valid,
    output logic             rec_bit,
    output logic [LEN_W-1:0] rec_len,
    output logic [CNT_W-1:0] run_count,
    output logic             ovf
`ifdef RUN_MAXLEN_EN
    ,
    output logic [LEN_W-1:0] max_len
`endif
);
    import run_reporter_pkg::*;

    typedef struct packed {
        logic             pol;
        logic [LEN_W-1:0] len;
    } rec_t;

    localparam logic [LEN_W-1:0] LEN_MAX   = '1;
    localparam logic [LEN_W-1:0] LEN_START = LEN_W'(MIN_RUN);

    state_t           r_state;
    logic             r_cur_bit;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_run_count;
    logic             r_ovf;
`ifdef RUN_MAXLEN_EN
    logic [LEN_W-1:0] r_max_len;
`endif

    rec_t w_wr_rec;
    rec_t w_rd_rec;
    logic w_close;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drop;

    // A run ends when the flag drops or (defensively) the polarity flips.
    assign w_close  = (r_state == IN_RUN) && (!match_in || (bit_in != r_cur_bit));
    assign w_pop    = rec_ready && !w_empty;
    assign w_drop   = w_close && w_full && !w_pop;
    assign w_wr_rec = '{pol: r_cur_bit, len: r_len};

    run_rec_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_close),
        .i_pop     (w_pop),
        .i_wr_data (w_wr_rec),
        .o_rd_data (w_rd_rec),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur_bit   <= 1'b0;
            r_len       <= '0;
            r_run_count <= '0;
            r_ovf       <= 1'b0;
`ifdef RUN_MAXLEN_EN
            r_max_len   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (match_in) begin
                        r_state   <= IN_RUN;
                        r_cur_bit <= bit_in;
                        r_len     <= LEN_START;
                    end
                end
                IN_RUN: begin
                    if (!match_in) begin
                        r_state <= IDLE;
                    end else if (bit_in != r_cur_bit) begin
                        r_cur_bit <= bit_in;
                        r_len     <= LEN_START;
                    end else if (r_len != LEN_MAX) begin
                        r_len <= r_len + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_close) r_run_count <= r_run_count + 1'b1;

            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;

`ifdef RUN_MAXLEN_EN
            if (w_close && (r_len > r_max_len)) r_max_len <= r_len;
`endif
        end
    end

    assign rec_valid = !w_empty;
    assign rec_bit   = rec_valid ? w_rd_rec.pol : 1'b0;
    assign rec_len   = rec_valid ? w_rd_rec.len : '0;
    assign run_count = r_run_count;
    assign ovf       = r_ovf;
`ifdef RUN_MAXLEN_EN
    assign max_len   = r_max_len;
`endif

endmodule

// File: tb/tb_run_reporter.sv
// ---------------------------------------------------------------------------
// tb_run_reporter
// Self-checking bench for run_reporter (LEN_W=4, DEPTH=4, CNT_W=16).
// A reference model counts match-high cycles per run, turns each closed run
// into a {polarity, min(cycles+2, 15)} record and keeps records in a queue of
// at most DEPTH entries; DUT outputs are compared #1 after every edge.
// ---------------------------------------------------------------------------
module tb_run_reporter;

    localparam int LEN_W = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LMAX  = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             match_in;
    logic             bit_in;
    logic             rec_ready;
    logic             ovf_clr;
    logic             rec_valid;
    logic             rec_bit;
    logic [LEN_W-1:0] rec_len;
    logic [CNT_W-1:0] run_count;
    logic             ovf;
`ifdef RUN_MAXLEN_EN
    logic [LEN_W-1:0] max_len;
`endif

    run_reporter #(
        .LEN_W (LEN_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .match_in  (match_in),
        .bit_in    (bit_in),
        .rec_ready (rec_ready),
        .ovf_clr   (ovf_clr),
        .rec_valid (rec_valid),
        .rec_bit   (rec_bit),
        .rec_len   (rec_len),
        .run_count (run_count),
        .ovf       (ovf)
`ifdef RUN_MAXLEN_EN
        ,
        .max_len   (max_len)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit pol;
        int len;
    } mrec_t;

    mrec_t mq[$];
    bit    m_in_run;
    bit    m_pol;
    int    m_cycles;
    int    m_count;
    bit    m_ovf;
    int    m_max;

    function automatic void model_reset();
        mq.delete();
        m_in_run = 0;
        m_pol    = 0;
        m_cycles = 0;
        m_count  = 0;
        m_ovf    = 0;
        m_max    = 0;
    endfunction

    // Apply one clock edge with the given sampled inputs.
    function automatic void model_edge(bit m, bit b, bit r, bit c);
        bit    popped   = (mq.size() > 0) && r;
        bit    was_full = (mq.size() == DEPTH);
        bit    close    = m_in_run && (!m || (b != m_pol));
        bit    drop     = 0;
        mrec_t rec;
        if (popped) void'(mq.pop_front());
        if (close) begin
            rec.pol = m_pol;
            rec.len = (m_cycles + 2 > LMAX) ? LMAX : m_cycles + 2;
            m_count = (m_count + 1) % (1 << CNT_W);
            if (rec.len > m_max) m_max = rec.len;
            if (!was_full || popped) mq.push_back(rec);
            else drop = 1;
        end
        if (drop)   m_ovf = 1;
        else if (c) m_ovf = 0;
        if (m) begin
            if (!m_in_run || close) begin
                m_in_run = 1;
                m_pol    = b;
                m_cycles = 1;
            end else begin
                m_cycles++;
            end
        end else begin
            m_in_run = 0;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        bit exp_bit = (mq.size() > 0) ? mq[0].pol : 1'b0;
        int exp_len = (mq.size() > 0) ? mq[0].len : 0;
        check({tag, ".rec_valid"}, 32'(rec_valid), 32'(mq.size() > 0));
        check({tag, ".rec_bit"},   32'(rec_bit),   32'(exp_bit));
        check({tag, ".rec_len"},   32'(rec_len),   32'(exp_len));
        check({tag, ".run_count"}, 32'(run_count), 32'(m_count));
        check({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
`ifdef RUN_MAXLEN_EN
        check({tag, ".max_len"},   32'(max_len),   32'(m_max));
`endif
    endtask

    task automatic step(input string tag, input bit m, input bit b, input bit r, input bit c);
        match_in  = m;
        bit_in    = b;
        rec_ready = r;
        ovf_clr   = c;
        @(posedge clk);
        model_edge(m, b, r, c);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all("reset");
        #2 rst = 1'b0;
    endtask

    int drained;

    initial begin
        rst       = 1'b1;
        match_in  = 1'b0;
        bit_in    = 1'b0;
        rec_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all("por");
        check("por.rec_valid_zero", 32'(rec_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a run discards the partial run.
        step("midrun", 1, 0, 0, 0);
        step("midrun", 1, 0, 0, 0);
        do_reset();
        check("midrun.rec_valid", 32'(rec_valid), 32'd0);
        check("midrun.run_count", 32'(run_count), 32'd0);
        step("midrun_fall", 0, 0, 0, 0);
        check("midrun_fall.no_record", 32'(rec_valid), 32'd0);

        // Zeros run, 3 flag cycles -> {0,5}, visible right after the fall edge.
        repeat (3) step("zeros", 1, 0, 1, 0);
        check("zeros.not_yet_valid", 32'(rec_valid), 32'd0);
        step("zeros_fall", 0, 0, 1, 0);
        check("zeros.valid", 32'(rec_valid), 32'd1);
        check("zeros.bit",   32'(rec_bit),   32'd0);
        check("zeros.len",   32'(rec_len),   32'd5);
        check("zeros.count", 32'(run_count), 32'd1);
        step("zeros_pop", 0, 0, 1, 0);
        check("zeros.popped", 32'(rec_valid), 32'd0);

        // Saturation: 20 flag cycles with LEN_W=4 -> {1,15}.
        repeat (20) step("sat", 1, 1, 0, 0);
        step("sat_fall", 0, 1, 0, 0);
        check("sat.bit", 32'(rec_bit), 32'd1);
        check("sat.len", 32'(rec_len), 32'd15);
        step("sat_hold", 0, 0, 0, 0);
        check("sat.held_len", 32'(rec_len), 32'd15);
        step("sat_pop", 0, 0, 1, 0);

        // Backpressure: five 1-cycle runs, consumer stalled -> one dropped.
        for (int i = 0; i < 5; i++) begin
            step("ovf_run", 1, i[0], 0, 0);
            step("ovf_fall", 0, 0, 0, 0);
        end
        check("ovf.flag",  32'(ovf),       32'd1);
        check("ovf.count", 32'(run_count), 32'd7);
        check("ovf.head_len", 32'(rec_len), 32'd3);
        check("ovf.head_bit", 32'(rec_bit), 32'd0);
        for (int i = 0; i < 4; i++) step("ovf_drain", 0, 0, 1, 0);
        check("ovf.drained", 32'(rec_valid), 32'd0);
        step("ovf_clr", 0, 0, 0, 1);
        check("ovf.cleared", 32'(ovf), 32'd0);

        // Full FIFO with a same-edge pop: nothing is dropped.
        for (int i = 0; i < 4; i++) begin
            step("full_run", 1, 1, 0, 0);
            step("full_fall", 0, 0, 0, 0);
        end
        step("full_last", 1, 0, 0, 0);
        step("full_close_pop", 0, 0, 1, 0);
        check("full.no_ovf", 32'(ovf), 32'd0);
        drained = 0;
        for (int i = 0; i < 10 && rec_valid; i++) begin
            drained++;
            step("full_drain", 0, 0, 1, 0);
        end
        check("full.occupancy", 32'(drained), 32'd4);

        // Polarity flip while the flag stays high -> {0,4} then {1,4}.
        do_reset();
        step("flip", 1, 0, 0, 0);
        step("flip", 1, 0, 0, 0);
        step("flip", 1, 1, 0, 0);
        step("flip", 1, 1, 0, 0);
        step("flip_fall", 0, 1, 0, 0);
        check("flip.first_bit", 32'(rec_bit), 32'd0);
        check("flip.first_len", 32'(rec_len), 32'd4);
        check("flip.count",     32'(run_count), 32'd2);
`ifdef RUN_MAXLEN_EN
        check("flip.max_len", 32'(max_len), 32'd4);
`endif
        step("flip_pop", 0, 0, 1, 0);
        check("flip.second_bit", 32'(rec_bit), 32'd1);
        check("flip.second_len", 32'(rec_len), 32'd4);
        step("flip_pop2", 0, 0, 1, 0);
        check("flip.empty", 32'(rec_valid), 32'd0);

        // Randomised traffic: bursty flag, sticky polarity, stalling consumer.
        begin
            bit b = 0;
            for (int i = 0; i < 600; i++) begin
                bit m = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) b = ~b;
                step("rand", m, b, ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 15) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_reporter.md
Name: run_reporter

Overview:
- Downstream consumer of the serial equal-run detector.
- Takes the detector's Moore match flag plus the serial bit (delayed one clock), delimits each run of ≥3 equal bits, and measures its length.
- Pushes one {polarity, length} record per run into a small FIFO drained through a valid/ready handshake by the host-side logger.
- Keeps a running count of completed runs and a sticky overflow flag.

Parameters:
- LEN_W, 8, width of run-length field; length saturates at 2^LEN_W-1.
- DEPTH, 4, record FIFO depth; power of two, ≥2.
- CNT_W, 16, width of completed-run counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- match_in  input  1  detector z output (high while last ≥3 serial bits are equal).
- bit_in  input  1  serial bit delayed one clock; equals run polarity whenever match_in=1.
- rec_ready  input  1  consumer accepts the head record this cycle.
- ovf_clr  input  1  synchronous clear of ovf.
- rec_valid  output  1  FIFO non-empty.
- rec_bit  output  1  head record polarity.
- rec_len  output  LEN_W  head record length in bits.
- run_count  output  CNT_W  total completed runs, including dropped ones.
- ovf  output  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset (async, any time, including mid-run): FSM→IDLE, length counter 0, FIFO emptied, rec_valid=0, rec_bit=0, rec_len=0, run_count=0, ovf=0. A partial run is discarded.
- FSM states are IDLE and IN_RUN.
- IDLE, match_in=1: go to IN_RUN, cur_bit<=bit_in, len<=3.
- IN_RUN, match_in=1, bit_in==cur_bit: len<=len+1, saturating at 2^LEN_W-1.
- IN_RUN, match_in=0: close the run (push {cur_bit,len}, run_count+1), then go to IDLE.
- IN_RUN, match_in=1, bit_in!=cur_bit: close the run, then restart in IN_RUN with cur_bit<=bit_in, len<=3. This is a defensive case; the detector never produces it.
- Resulting length = (cycles match_in was high) + 2.
- Latency: the push occurs on the edge that samples the first low match_in. When the FIFO was empty, rec_valid rises right after that edge, so the record is visible one cycle after match_in falls.
- Pop: on a clock edge with rec_valid=1 and rec_ready=1. rec_ready while rec_valid=0 is ignored.
- rec_bit/rec_len reflect the FIFO head combinationally and are held stable while rec_valid=1 and rec_ready=0.
- Full FIFO with a push:
  - If a pop happens the same edge, both occur and nothing is lost.
  - Otherwise the record is dropped, ovf<=1, and run_count still increments.
- Empty FIFO with a push: the record is written; rec_valid=1 next cycle with no bypass.
- ovf_clr and a new drop on the same edge: ovf ends at 1 (set wins).
- Pointers are log2(DEPTH)+1 bits wide. full = MSBs differ and the rest are equal; empty = pointers equal.

Optional Feature:
- Macro RUN_MAXLEN_EN.
- Defined: adds output max_len [LEN_W], reset 0, updated on every run close (dropped runs included) to max(max_len, closed len).
- Undefined: no port, no register.

Decomposition:
- Package run_reporter_pkg holds:
  - the state enum {IDLE, IN_RUN};
  - a parameterised record typedef {bit pol; logic [LEN_W-1:0] len};
  - the constant MIN_RUN=3.
- Sub-module run_rec_fifo: a synchronous FIFO of records with DEPTH/width parameters, push/pop/full/empty. Top level holds the FSM, length counter, run_count and ovf.

Test Plan:
- Reset mid-run: match_in high for 2 cycles, assert rst → rec_valid=0, run_count=0; next run records normally.
- Zeros run: match_in high 3 cycles with bit_in=0, rec_ready=1 → one record {0,5}, rec_valid high exactly one cycle after match_in falls; run_count=1.
- Saturation (LEN_W=4): match_in high 20 cycles, bit_in=1 → record {1,15}.
- Backpressure/overflow (DEPTH=4): 5 short runs (1 cycle each, len=3) with rec_ready=0 → 4 records held, ovf=1, run_count=5. Drain → records {x,3} ×4 in order, then rec_valid=0. ovf_clr → ovf=0.
- Full with simultaneous pop: FIFO full, rec_ready=1 on the edge a run closes → no drop, ovf stays 0, occupancy stays 4.
- Polarity flip while match_in stays high (2 cycles bit 0, then 2 cycles bit 1) → records {0,4} then {1,4} after fall. With RUN_MAXLEN_EN → max_len=4.
